button_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the game logic in top.
- Takes the raw asynchronous board buttons right/left/fire.
- Produces clean, debounced, single-clock-domain control signals: a direction state, a periodic move step and a rate-limited fire pulse.
- Player-ship and projectile logic consume these outputs instead of raw pins.

---
 rtl/button_conditioner.sv | 150 +++++++++++++++
 tb/tb_button_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Conditions raw right/left/fire buttons: 2-flop synchronizer, per-channel debounce,
// last-pressed-wins direction FSM with periodic move ticks, and a rate-limited fire pulse.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int MOVE_PERIOD     = 1041667,
    parameter int COOLDOWN_CYCLES = 31250000
) (
    input  logic       clk125,
    input  logic       rst,
    input  logic       right,
    input  logic       left,
    input  logic       fire,
    output logic       move_right,
    output logic       move_left,
    output logic       move_tick,
    output logic       fire_pulse,
    output logic [2:0] btn_stable
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TKW = $clog2(MOVE_PERIOD + 1);
    localparam int CDW = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TKW-1:0] TK_LAST = TKW'(MOVE_PERIOD - 1);
    localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RIGHT = 2'd1,
        ST_LEFT  = 2'd2
    } dir_state_t;

    // Channel order everywhere: bit 0 = right, bit 1 = left, bit 2 = fire.
    logic [2:0]     w_raw;
    logic [2:0]     r_sync1;
    logic [2:0]     r_sync2;
    logic [2:0]     r_stable;
    logic [2:0]     r_stable_d1;
    logic [DBW-1:0] r_db_cnt [3];
    logic [2:0]     w_rise;

    dir_state_t     r_state;
    dir_state_t     w_next;
    logic [TKW-1:0] r_tick_cnt;
    logic [CDW-1:0] r_cooldown;

    assign w_raw      = {fire, left, right};
    assign w_rise     = r_stable & ~r_stable_d1;
    assign btn_stable = r_stable;

    always_ff @(posedge clk125) begin
        if (rst) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_stable    <= '0;
            r_stable_d1 <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1     <= w_raw;
            r_sync2     <= r_sync1;
            r_stable_d1 <= r_stable;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // A fresh press always takes over; a release falls back to whatever is still held.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise[0] && !w_rise[1]) begin
                    w_next = ST_RIGHT;
                end else if (w_rise[1] && !w_rise[0]) begin
                    w_next = ST_LEFT;
                end
            end
            ST_RIGHT: begin
                if (w_rise[1]) begin
                    w_next = ST_LEFT;
                end else if (!r_stable[0]) begin
                    w_next = r_stable[1] ? ST_LEFT : ST_IDLE;
                end
            end
            ST_LEFT: begin
                if (w_rise[0]) begin
                    w_next = ST_RIGHT;
                end else if (!r_stable[1]) begin
                    w_next = r_stable[0] ? ST_RIGHT : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_ff @(posedge clk125) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            move_right <= 1'b0;
            move_left  <= 1'b0;
            move_tick  <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_state    <= w_next;
            move_right <= (w_next == ST_RIGHT);
            move_left  <= (w_next == ST_LEFT);
            if (w_next != r_state) begin
                r_tick_cnt <= '0;
                move_tick  <= (w_next != ST_IDLE);
            end else if (r_state == ST_IDLE) begin
                r_tick_cnt <= '0;
                move_tick  <= 1'b0;
            end else if (r_tick_cnt == TK_LAST) begin
                r_tick_cnt <= '0;
                move_tick  <= 1'b1;
            end else begin
                r_tick_cnt <= r_tick_cnt + TKW'(1);
                move_tick  <= 1'b0;
            end
        end
    end

    // Rises arriving while the cooldown is running are discarded, never queued.
    always_ff @(posedge clk125) begin
        if (rst) begin
            fire_pulse <= 1'b0;
            r_cooldown <= '0;
        end else if (w_rise[2] && (r_cooldown == '0)) begin
            fire_pulse <= 1'b1;
            r_cooldown <= CD_LOAD;
        end else begin
            fire_pulse <= 1'b0;
            if (r_cooldown != '0) begin
                r_cooldown <= r_cooldown - CDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed vector table for the multi-cycle scenarios, then
// random button activity, every cycle compared against a timestamp-based reference model.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int MP = 8;
  localparam int CD = 16;

  logic       clk125;
  logic       rst;
  logic [2:0] btn;
  logic       move_right;
  logic       move_left;
  logic       move_tick;
  logic       fire_pulse;
  logic [2:0] btn_stable;
  logic [6:0] dut_out;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .MOVE_PERIOD    (MP),
    .COOLDOWN_CYCLES(CD)
  ) dut (
    .clk125    (clk125),
    .rst       (rst),
    .right     (btn[0]),
    .left      (btn[1]),
    .fire      (btn[2]),
    .move_right(move_right),
    .move_left (move_left),
    .move_tick (move_tick),
    .fire_pulse(fire_pulse),
    .btn_stable(btn_stable)
  );

  assign dut_out = {move_right, move_left, move_tick, fire_pulse, btn_stable};

  // clock / reset
  initial clk125 = 1'b0;
  always #4 clk125 = ~clk125;

  // scoreboard
  logic [6:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got {mr,ml,tick,pulse,stable}=%b expected %b", name, $time, got, exp);
    end
  endtask

  // reference model: edge counter, event timestamps, run lengths
  int         cyc = 0;
  logic [2:0] m_s1, m_s2, m_stable, m_prev;
  int         m_run[3];
  int         m_dir;          // 0 idle, 1 right, 2 left
  int         m_dir_since;
  bit         m_fired;
  int         m_last_fire;
  bit         m_tick, m_pulse;

  function automatic int next_dir(input int d, input logic [2:0] r, input logic [2:0] s);
    int n;
    n = d;
    if (d == 0) begin
      if (r[0] && !r[1]) n = 1;
      else if (r[1] && !r[0]) n = 2;
    end else if (d == 1) begin
      if (r[1]) n = 2;
      else if (!s[0]) n = s[1] ? 2 : 0;
    end else begin
      if (r[0]) n = 1;
      else if (!s[1]) n = s[0] ? 1 : 0;
    end
    return n;
  endfunction

  task automatic model_step(input logic rst_i, input logic [2:0] pins);
    logic [2:0] sync_old;
    logic [2:0] stable_old;
    logic [2:0] rise;
    int nd;
    cyc++;
    if (rst_i) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_dir = 0; m_dir_since = cyc; m_fired = 0; m_last_fire = 0;
      m_tick = 0; m_pulse = 0;
    end else begin
      sync_old   = m_s2;
      m_s2       = m_s1;
      m_s1       = pins;
      stable_old = m_stable;
      rise       = stable_old & ~m_prev;
      m_prev     = stable_old;
      for (int i = 0; i < 3; i++) begin
        if (sync_old[i] != stable_old[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_stable[i] = sync_old[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      nd = next_dir(m_dir, rise, stable_old);
      if (nd != m_dir) begin
        m_dir = nd;
        m_dir_since = cyc;
      end
      m_tick  = (m_dir != 0) && (((cyc - m_dir_since) % MP) == 0);
      m_pulse = rise[2] && (!m_fired || ((cyc - m_last_fire) >= CD));
      if (m_pulse) begin
        m_fired = 1;
        m_last_fire = cyc;
      end
    end
    exp_q.push_back({(m_dir == 1), (m_dir == 2), m_tick, m_pulse, m_stable});
  endtask

  // driver: one clock edge, then model update and per-cycle comparison
  task automatic step();
    logic [6:0] e;
    @(posedge clk125);
    #1;
    model_step(rst, btn);
    e = exp_q.pop_front();
    check("model", dut_out, e);
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] btn;
    int         n;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] b, input int n, input logic [6:0] e,
                     input string name);
    vec_t v;
    v.rst = r; v.btn = b; v.n = n; v.exp = e; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    btn = 3'b000;

    // btn = {fire,left,right}; exp = {move_right,move_left,move_tick,fire_pulse,btn_stable}
    add(1, 3'b000, 3,  7'b0000_000, "reset_idle");
    add(0, 3'b001, 3,  7'b0000_000, "glitch_hold");
    add(0, 3'b000, 10, 7'b0000_000, "glitch_reject");
    add(0, 3'b001, 5,  7'b0000_000, "db_not_yet");
    add(0, 3'b001, 1,  7'b0000_001, "db_stable_at_6");
    add(0, 3'b001, 1,  7'b1010_001, "right_first_tick");
    add(0, 3'b001, 1,  7'b1000_001, "right_no_tick");
    add(0, 3'b001, 6,  7'b1000_001, "right_mid_period");
    add(0, 3'b001, 1,  7'b1010_001, "right_tick_period");
    add(0, 3'b000, 5,  7'b1000_001, "rel_pending");
    add(0, 3'b000, 1,  7'b1000_000, "rel_stable_low");
    add(0, 3'b000, 1,  7'b0000_000, "rel_idle");
    add(0, 3'b000, 10, 7'b0000_000, "idle_no_tick");
    add(0, 3'b001, 7,  7'b1010_001, "lp_right");
    add(0, 3'b011, 5,  7'b1000_001, "lp_left_pending");
    add(0, 3'b011, 1,  7'b1000_011, "lp_left_stable");
    add(0, 3'b011, 1,  7'b0110_011, "lp_left_wins");
    add(0, 3'b011, 8,  7'b0110_011, "lp_left_period");
    add(0, 3'b011, 1,  7'b0100_011, "lp_left_hold");
    add(0, 3'b001, 6,  7'b0100_001, "lp_left_release");
    add(0, 3'b001, 1,  7'b1010_001, "lp_back_right");
    add(0, 3'b000, 12, 7'b0000_000, "lp_all_release");
    add(0, 3'b100, 6,  7'b0000_100, "f1_stable");
    add(0, 3'b100, 1,  7'b0001_100, "f1_pulse");
    add(0, 3'b100, 3,  7'b0000_100, "f1_no_repeat");
    add(0, 3'b000, 4,  7'b0000_100, "f1_release");
    add(0, 3'b100, 5,  7'b0000_000, "f2_press");
    add(0, 3'b000, 1,  7'b0000_100, "f2_stable");
    add(0, 3'b000, 1,  7'b0000_100, "f2_dropped");
    add(0, 3'b000, 5,  7'b0000_000, "f2_release");
    add(0, 3'b100, 5,  7'b0000_000, "f3_press");
    add(0, 3'b100, 1,  7'b0000_100, "f3_stable");
    add(0, 3'b100, 1,  7'b0001_100, "f3_pulse");
    add(0, 3'b000, 20, 7'b0000_000, "f3_release");
    add(0, 3'b101, 7,  7'b1011_101, "mr_right_and_fire");
    add(0, 3'b101, 2,  7'b1000_101, "mr_cooldown_active");
    add(1, 3'b000, 1,  7'b0000_000, "mr_reset");
    add(0, 3'b100, 5,  7'b0000_000, "mr_fire_press");
    add(0, 3'b100, 1,  7'b0000_100, "mr_fire_stable");
    add(0, 3'b100, 1,  7'b0001_100, "mr_fire_pulse");
    add(0, 3'b000, 12, 7'b0000_000, "mr_release");

    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst;
      btn = vecs[k].btn;
      repeat (vecs[k].n) step();
      check(vecs[k].name, dut_out, vecs[k].exp);
    end

    // random button activity with occasional resets
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (rst) begin
        if ($urandom_range(0, 2) == 0) rst = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
